program_loader: RTL and testbench

Synthesizable program loader sitting between an external word source (host/UART/JTAG bridge) and the pipelined processor's instruction memory write port. It holds the processor in reset and accepts a stream of instruction words over a valid/ready handshake. Each accepted word is written to consecutive addresses starting at a configurable base. After the last word it keeps the processor in reset for a fixed number of cycles, then releases it. Width, base address, capacity and release delay are parameters; word count, a checksum and overflow errors are reported.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding of the load sequencer.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // States in which a start request opens a new load session.
    function automatic logic start_allowed(input state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams instruction words into the processor's instruction memory while
// holding the processor in reset, then releases it after a fixed hold delay.
//
// state | meaning
// IDLE  | after reset, processor held, waiting for start
// LOAD  | accepting words, one memory write per accepted word
// HOLD  | last word written, processor still held for HOLD_CYCLES
// RUN   | processor released, program running
// ERR   | session overflowed capacity, processor held
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h20,
    parameter int                MAX_WORDS   = 1024,
    parameter int                HOLD_CYCLES = 2,
    parameter int                CNT_W       = $clog2(MAX_WORDS + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word_data,
    input  logic              i_word_last,
    output logic              o_word_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_word_count,
    output logic [DATA_W-1:0] o_checksum
);

    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_word_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [CNT_W-1:0]    r_word_count;
    logic [DATA_W-1:0]   r_checksum;

    logic w_accept;
    logic w_full;
    logic w_write;
    logic w_hold_tc;
    logic w_session_start;

    // Ready is a function of state only, so accept needs no ready feedback path.
    assign w_accept        = (r_state == ST_LOAD) && i_word_valid;
    assign w_full          = (r_word_count == CNT_W'(MAX_WORDS));
    assign w_write         = w_accept && !w_full;
    assign w_hold_tc       = (r_hold_cnt == '0);
    assign w_session_start = i_start && start_allowed(r_state);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_full) begin
                        w_state_nxt = ST_ERR;
                    end else if (i_word_last) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_hold_tc) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loaded with HOLD_CYCLES-1 on the last write; HOLD exits on terminal count.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_hold_cnt <= '0;
        end else if (w_write && i_word_last) begin
            r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        end else if ((r_state == ST_HOLD) && !w_hold_tc) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
        end else begin
            r_mem_we <= w_write;
            if (w_write) begin
                r_mem_addr   <= BASE_ADDR + ADDR_W'(r_word_count);
                r_mem_wdata  <= i_word_data;
                r_word_count <= r_word_count + CNT_W'(1);
                r_checksum   <= r_checksum + i_word_data;
            end else if (w_session_start) begin
                r_word_count <= '0;
                r_checksum   <= '0;
            end
        end
    end

    // Status outputs are registered from the next state so they change with it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_word_ready <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_word_ready <= (w_state_nxt == ST_LOAD);
            r_cpu_reset  <= (w_state_nxt != ST_RUN);
            r_busy       <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_HOLD);
            r_done       <= (w_state_nxt == ST_RUN);
            r_error      <= (w_state_nxt == ST_ERR);
        end
    end

    assign o_word_ready = r_word_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;
    assign o_checksum   = r_checksum;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a default instance and a small-capacity, longer-hold
// instance share one stimulus stream and are compared against a session-level model.
module tb_program_loader;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_HOLD = 2;
    localparam int M_RUN  = 3;
    localparam int M_ERR  = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        last;

    logic        a_ready, a_we, a_cpu, a_busy, a_done, a_err;
    logic [31:0] a_addr;
    logic [15:0] a_wdata, a_sum;
    logic [10:0] a_cnt;
    logic        b_ready, b_we, b_cpu, b_busy, b_done, b_err;
    logic [31:0] b_addr;
    logic [15:0] b_wdata, b_sum;
    logic [2:0]  b_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          maxw [2] = '{1024, 4};
    int          holdc[2] = '{2, 3};
    int          m_mode[2];
    int          m_cnt[2];
    int          m_rel[2];
    logic [15:0] m_sum[2];
    logic        m_we[2];
    logic [31:0] m_addr[2];
    logic [15:0] m_wdata[2];

    program_loader dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_word_valid(valid),
        .i_word_data(data), .i_word_last(last), .o_word_ready(a_ready), .o_mem_we(a_we),
        .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_cpu_reset(a_cpu), .o_busy(a_busy),
        .o_done(a_done), .o_error(a_err), .o_word_count(a_cnt), .o_checksum(a_sum)
    );

    program_loader #(.MAX_WORDS(4), .HOLD_CYCLES(3)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_word_valid(valid),
        .i_word_data(data), .i_word_last(last), .o_word_ready(b_ready), .o_mem_we(b_we),
        .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_cpu_reset(b_cpu), .o_busy(b_busy),
        .o_done(b_done), .o_error(b_err), .o_word_count(b_cnt), .o_checksum(b_sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int i, input string p, input logic rdy, input logic we,
                             input logic [31:0] addr, input logic [15:0] wd, input logic cpu,
                             input logic busy, input logic done, input logic err,
                             input logic [10:0] cnt, input logic [15:0] sum);
        chk({p, ".word_ready"}, 64'(rdy),  64'(m_mode[i] == M_LOAD));
        chk({p, ".mem_we"},     64'(we),   64'(m_we[i]));
        chk({p, ".mem_addr"},   64'(addr), 64'(m_addr[i]));
        chk({p, ".mem_wdata"},  64'(wd),   64'(m_wdata[i]));
        chk({p, ".cpu_reset"},  64'(cpu),  64'(m_mode[i] != M_RUN));
        chk({p, ".busy"},       64'(busy), 64'((m_mode[i] == M_LOAD) || (m_mode[i] == M_HOLD)));
        chk({p, ".done"},       64'(done), 64'(m_mode[i] == M_RUN));
        chk({p, ".error"},      64'(err),  64'(m_mode[i] == M_ERR));
        chk({p, ".word_count"}, 64'(cnt),  64'(m_cnt[i]));
        chk({p, ".checksum"},   64'(sum),  64'(m_sum[i]));
    endtask

    // Model advances one clock edge using the inputs currently applied.
    task automatic tick();
        int e;
        e = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_mode[i]  = M_IDLE;
                m_cnt[i]   = 0;
                m_sum[i]   = '0;
                m_we[i]    = 1'b0;
                m_addr[i]  = 32'h20;
                m_wdata[i] = '0;
            end else begin
                m_we[i] = 1'b0;
                if (m_mode[i] == M_LOAD) begin
                    if (valid) begin
                        if (m_cnt[i] < maxw[i]) begin
                            m_we[i]    = 1'b1;
                            m_addr[i]  = 32'h20 + 32'(m_cnt[i]);
                            m_wdata[i] = data;
                            m_cnt[i]   = m_cnt[i] + 1;
                            m_sum[i]   = m_sum[i] + data;
                            if (last) begin
                                m_mode[i] = M_HOLD;
                                m_rel[i]  = e + holdc[i];
                            end
                        end else begin
                            m_mode[i] = M_ERR;
                        end
                    end
                end else if (m_mode[i] == M_HOLD) begin
                    if (e >= m_rel[i]) m_mode[i] = M_RUN;
                end else if (start) begin
                    m_mode[i] = M_LOAD;
                    m_cnt[i]  = 0;
                    m_sum[i]  = '0;
                end
            end
        end
        @(posedge clk);
        cyc = e;
        #1;
        check_dut(0, "a", a_ready, a_we, a_addr, a_wdata, a_cpu, a_busy, a_done, a_err, a_cnt, a_sum);
        check_dut(1, "b", b_ready, b_we, b_addr, b_wdata, b_cpu, b_busy, b_done, b_err, 11'(b_cnt), b_sum);
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        data  = 16'(($urandom));
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        start = 1'b0;
        valid = 1'b1;
        data  = d;
        last  = l;
        tick();
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] words[3] = '{16'h453F, 16'h653F, 16'h8C3D};
    logic        pat[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int nw;
        int len;
        int sent;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_sum[i] = '0; m_rel[i] = 0;
            m_we[i] = 1'b0; m_addr[i] = 32'h20; m_wdata[i] = '0;
        end
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_addr", 64'(a_addr), 64'h20);
        chk("rst_cpu_reset", 64'(a_cpu), 64'h1);
        reset_n = 1'b1;
        tick();

        // Three-word load at defaults
        do_start();
        chk("start_ready", 64'(a_ready), 64'h1);
        for (int j = 0; j < 3; j++) begin
            send(words[j], j == 2);
            chk("tp1_addr", 64'(a_addr), 64'h20 + 64'(j));
        end
        idle_inputs();
        chk("tp1_count", 64'(a_cnt), 64'd3);
        chk("tp1_checksum", 64'(a_sum), 64'h36BB);
        tick();
        chk("tp1_hold_a", 64'(a_cpu), 64'h1);
        tick();
        chk("tp1_release_a", 64'(a_cpu), 64'h0);
        chk("tp1_done_a", 64'(a_done), 64'h1);
        chk("tp1_hold_b", 64'(b_cpu), 64'h1);
        tick();
        chk("tp1_release_b", 64'(b_cpu), 64'h0);
        tick();

        // Gapped valid with a reload from RUN
        do_start();
        nw = 0;
        for (int j = 0; j < 7; j++) begin
            valid = pat[j];
            data  = 16'($urandom);
            last  = (j == 6);
            tick();
            chk("gap_we", 64'(a_we), 64'(pat[j]));
            if (a_we) begin
                chk("gap_addr", 64'(a_addr), 64'h20 + 64'(nw));
                nw++;
            end
        end
        idle_inputs();
        chk("gap_writes", 64'(nw), 64'd4);
        for (int j = 0; j < 5; j++) tick();

        // Overflow on the 4-word instance, then clear with start
        do_start();
        for (int j = 0; j < 5; j++) send(16'($urandom), 1'b0);
        idle_inputs();
        tick();
        chk("ovf_b_error", 64'(b_err), 64'h1);
        chk("ovf_b_count", 64'(b_cnt), 64'd4);
        chk("ovf_b_cpu", 64'(b_cpu), 64'h1);
        chk("ovf_a_count", 64'(a_cnt), 64'd5);
        send(16'h1234, 1'b1);
        idle_inputs();
        for (int j = 0; j < 5; j++) tick();
        chk("ovf_b_still_err", 64'(b_err), 64'h1);
        do_start();
        chk("ovf_b_cleared", 64'(b_err), 64'h0);

        // Reset in the cycle after the second accept
        send(16'($urandom), 1'b0);
        send(16'($urandom), 1'b0);
        idle_inputs();
        reset_n = 1'b0;
        tick();
        chk("rst_mid_we", 64'(a_we), 64'h0);
        chk("rst_mid_count", 64'(a_cnt), 64'd0);
        reset_n = 1'b1;
        tick();

        // Randomized sessions with gaps, stray valids and stray starts
        for (int s = 0; s < 12; s++) begin
            do_start();
            len  = int'($urandom_range(1, 7));
            sent = 0;
            for (int g = 0; g < 40 && sent < len; g++) begin
                valid = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                data  = 16'($urandom);
                last  = valid && (sent == len - 1);
                tick();
                if (valid) sent++;
            end
            for (int j = 0; j < 6; j++) begin
                idle_inputs();
                valid = ($urandom_range(0, 1) == 1);
                tick();
            end
        end

        // Reload from RUN starts writing at the base address again
        idle_inputs();
        do_start();
        for (int j = 0; j < 3; j++) send(words[j], j == 2);
        idle_inputs();
        for (int j = 0; j < 4; j++) tick();
        chk("rerun_done", 64'(a_done), 64'h1);
        do_start();
        chk("rerun_cpu", 64'(a_cpu), 64'h1);
        chk("rerun_count", 64'(a_cnt), 64'd0);
        send(16'hBEEF, 1'b0);
        chk("rerun_addr", 64'(a_addr), 64'h20);
        chk("rerun_we", 64'(a_we), 64'h1);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
